fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//   Fetch stage of the P7 pipeline. Owns the architectural fetch PC and drives instruction-memory addressing.
//   Produces pc / instr / DelaySlot / EXCcode for the F/D pipeline register (DREG) directly downstream.
//   Handles redirects with fixed priority: reset, exception entry (Req), eret return, stall, branch/jump, sequential.
//   Detects fetch address errors (AdEL) and squashes the fetched word to a nop.
// PARAMETERS
//   RESET_PC    32'h0000_3000  PC value after reset
//   HANDLER_PC  32'h0000_4180  exception handler entry PC
//   IM_BASE     32'h0000_3000  lowest legal fetch address
//   IM_END      32'h0000_6FFC  highest legal fetch address (inclusive)
//   EXC_ADEL    5'd4           EXCcode reported for an illegal fetch
// PORTS
//   clk           in   1   clock; all state updates on posedge
//   reset         in   1   synchronous, active-high reset
//   Req           in   1   CP0 exception/interrupt request; flush and redirect to HANDLER_PC
//   WE            in   1   PC write enable; 0 = stall, hold PC (same signal as DREG WE)
//   D_redirect    in   1   D-stage branch taken or jump
//   D_target      in   32  branch/jump target from D stage
//   D_is_cti      in   1   D stage holds a branch/jump; current F word is its delay slot
//   D_eret        in   1   D stage holds eret
//   EPC           in   32  CP0 EPC, eret return address
//   i_inst_rdata  in   32  instruction memory read data for i_inst_addr (combinational read)
//   i_inst_addr   out  32  instruction memory address (= F_pc)
//   F_pc          out  32  current fetch PC
//   F_instr       out  32  fetched instruction, or 32'h0 when squashed
//   F_DelaySlot   out  1   F word is a delay-slot instruction
//   F_EXCcode     out  5   0 = no exception, EXC_ADEL on an illegal fetch
// BEHAVIOUR
//   State: pc_q[31:0]; eret_sq_q (1 bit).
//   Reset: pc_q = RESET_PC, eret_sq_q = 0, so F_pc = 0x3000 and F_EXCcode = 0 in the first cycle after reset.
//   Next PC priority, evaluated at posedge:
//     1. reset                      -> RESET_PC.
//     2. Req                        -> HANDLER_PC. Overrides a stall (WE ignored).
//     3. !WE                        -> hold pc_q.
//     4. D_eret                     -> EPC; set eret_sq_q = 1.
//     5. D_redirect                 -> D_target.
//     6. else                       -> pc_q + 4. Wraps modulo 2^32, no saturation.
//   eret_sq_q clears on any cycle with WE=1, or on Req or reset, unless rule 4 fires in that cycle.
//   Squash (combinational): sq = D_eret | adel. eret has no delay slot, so the word after eret never issues.
//   F_instr = sq ? 32'h0 : i_inst_rdata.
//   AdEL: adel = (pc_q[1:0] != 0) | (pc_q < IM_BASE) | (pc_q > IM_END). Unsigned compare.
//   F_EXCcode = adel ? EXC_ADEL : 0. The eret squash reports no exception.
//   F_DelaySlot = D_is_cti & ~D_eret. It stays valid on an AdEL fetch so CP0 can set BD correctly.
//   i_inst_addr = pc_q. No latency: address and data belong to the same cycle.
//   Latency: a redirect presented in cycle N appears on F_pc in cycle N+1.
//   Simultaneous events:
//     Req + D_eret or Req + D_redirect: Req wins.
//     D_eret + D_redirect: eret wins; this is illegal in the ISA but must be deterministic.
//     Stall + redirect: redirect is held off. D is stalled too, so the request stays asserted and is taken on the first WE=1 cycle.
//   Reset asserted mid-stall or mid-redirect wins unconditionally.
//   An illegal PC is still incremented, so fetch continues until Req arrives.
// STRUCTURE
//   Shared const.v defines: RESET_PC, HANDLER_PC, IM_BASE, IM_END, EXC_ADEL, and EXC_NONE (5'd0).
//   CP0 and DREG reuse the same constants.
//   One natural sub-module, fetch_addr_check: pure combinational AdEL detector, input pc, output adel.
//   The rest stays flat: the PC register and the next-PC priority mux.
// TESTING
//   1. Reset, then 3 cycles WE=1, no redirects -> F_pc = 0x3000, 0x3004, 0x3008. F_EXCcode = 0.
//   2. At PC 0x3010: D_redirect=1, D_target=0x3100 -> next F_pc = 0x3100.
//      D_is_cti=1 in the redirect cycle -> F_DelaySlot = 1.
//   3. Stall (WE=0) at 0x3020, with Req=1 in the second stall cycle -> F_pc = 0x4180 next cycle, despite the stall.
//   4. D_eret=1 with EPC=0x3044, WE=1 -> F_instr = 0 that cycle and F_pc = 0x3044 next cycle.
//      Repeat with WE=0 -> PC held until WE=1.
//   5. D_target=0x3002 -> F_EXCcode = 4, F_instr = 0.
//      D_target=0x7000 -> F_EXCcode = 4.
//      Then Req -> F_pc = 0x4180 and F_EXCcode = 0.
//   6. Reset asserted for one cycle while D_redirect=1 and Req=1 -> F_pc = 0x3000.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: shared fetch constants and next-PC source selector
package fetch_pc_unit_pkg;
   localparam logic [31:0] RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
   localparam logic [31:0] IM_BASE    = 32'h0000_3000;
   localparam logic [31:0] IM_END     = 32'h0000_6FFC;
   localparam logic [4:0]  EXC_ADEL   = 5'd4;
   localparam logic [4:0]  EXC_NONE   = 5'd0;
   typedef enum logic [2:0] {SEL_EXC, SEL_HOLD, SEL_ERET, SEL_BR, SEL_SEQ} pc_sel_e;
endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: fetch-stage control inputs, instruction memory port and F-stage outputs
interface fetch_pc_unit_if;
   logic        Req;
   logic        WE;
   logic        D_redirect;
   logic [31:0] D_target;
   logic        D_is_cti;
   logic        D_eret;
   logic [31:0] EPC;
   logic [31:0] i_inst_rdata;
   logic [31:0] i_inst_addr;
   logic [31:0] F_pc;
   logic [31:0] F_instr;
   logic        F_DelaySlot;
   logic [4:0]  F_EXCcode;
   logic        eret_sq;
   modport master (
      output Req, WE, D_redirect, D_target, D_is_cti, D_eret, EPC, i_inst_rdata,
      input  i_inst_addr, F_pc, F_instr, F_DelaySlot, F_EXCcode, eret_sq
   );
   modport slave (
      input  Req, WE, D_redirect, D_target, D_is_cti, D_eret, EPC, i_inst_rdata,
      output i_inst_addr, F_pc, F_instr, F_DelaySlot, F_EXCcode, eret_sq
   );
endinterface

// File: rtl/fetch_pc_unit_addr_check.sv
// fetch_addr_check: flags misaligned or out-of-range instruction fetch addresses
module fetch_addr_check
   import fetch_pc_unit_pkg::*;
(
   input  logic [31:0] pc,
   output logic        adel
);
   assign adel = (pc[1:0] != 2'b00) | (pc < IM_BASE) | (pc > IM_END);
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch PC register, prioritised redirect mux and fetch squash
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   fetch_pc_unit_if.slave  bus
);
   logic [31:0] pc_q, pc_d;
   logic        eret_sq_q, eret_sq_d, adel;
   pc_sel_e     sel;
   fetch_addr_check u_chk (.pc(pc_q), .adel(adel));
   always_comb begin
      sel       = bus.Req ? SEL_EXC : !bus.WE ? SEL_HOLD : bus.D_eret ? SEL_ERET :
                  bus.D_redirect ? SEL_BR : SEL_SEQ;
      pc_d      = sel == SEL_EXC  ? HANDLER_PC :
                  sel == SEL_HOLD ? pc_q :
                  sel == SEL_ERET ? bus.EPC :
                  sel == SEL_BR   ? bus.D_target : pc_q + 32'd4;
      eret_sq_d = (sel == SEL_ERET) | ((sel == SEL_HOLD) & eret_sq_q);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q      <= RESET_PC;
         eret_sq_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         eret_sq_q <= eret_sq_d;
      end
   end
   // eret has no delay slot, so the word fetched alongside it is dropped
   assign bus.i_inst_addr = pc_q;
   assign bus.F_pc        = pc_q;
   assign bus.F_instr     = (bus.D_eret | adel) ? 32'h0 : bus.i_inst_rdata;
   assign bus.F_EXCcode   = adel ? EXC_ADEL : EXC_NONE;
   assign bus.F_DelaySlot = bus.D_is_cti & ~bus.D_eret;
   assign bus.eret_sq     = eret_sq_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: cycle-vector table with scoreboard for the fetch PC unit
module tb_fetch_pc_unit;
   import fetch_pc_unit_pkg::*;
   typedef struct {
      logic        rst, req, we, redir, cti, eret;
      logic [31:0] tgt, epc;
      logic [31:0] pc;
      logic        sq, ds, esq;
      logic [4:0]  exc;
   } vec_t;
   logic clk = 1'b0;
   logic reset;
   int n_chk = 0;
   int n_fail = 0;
   vec_t tbl[$];
   vec_t sb[$];
   fetch_pc_unit_if bus ();
   fetch_pc_unit dut (.clk(clk), .reset(reset), .bus(bus));
   assign bus.i_inst_rdata = ~bus.i_inst_addr;
   always #5 clk = ~clk;
   function automatic vec_t v(logic rst, logic req, logic we, logic redir, logic [31:0] tgt,
                              logic cti, logic eret, logic [31:0] epc, logic [31:0] pc,
                              logic sq, logic ds, logic [4:0] exc, logic esq);
      vec_t r;
      r.rst = rst; r.req = req; r.we = we; r.redir = redir; r.tgt = tgt; r.cti = cti;
      r.eret = eret; r.epc = epc; r.pc = pc; r.sq = sq; r.ds = ds; r.exc = exc; r.esq = esq;
      return r;
   endfunction
   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask
   task automatic step(vec_t r, string tag);
      vec_t e;
      reset = r.rst; bus.Req = r.req; bus.WE = r.we; bus.D_redirect = r.redir;
      bus.D_target = r.tgt; bus.D_is_cti = r.cti; bus.D_eret = r.eret; bus.EPC = r.epc;
      sb.push_back(r);
      @(negedge clk);
      if (sb.size() == 0) begin
         n_chk++; n_fail++;
         $display("FAIL %s scoreboard: got empty expected entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, " pc"}, bus.F_pc, e.pc);
         chk({tag, " addr"}, bus.i_inst_addr, e.pc);
         chk({tag, " instr"}, bus.F_instr, e.sq ? 32'h0 : ~e.pc);
         chk({tag, " ds"}, {31'h0, bus.F_DelaySlot}, {31'h0, e.ds});
         chk({tag, " exc"}, {27'h0, bus.F_EXCcode}, {27'h0, e.exc});
         chk({tag, " esq"}, {31'h0, bus.eret_sq}, {31'h0, e.esq});
      end
      @(posedge clk); #1;
   endtask
   initial begin
      //         rst req we rdr tgt           cti ert epc           pc            sq ds exc esq
      tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3000, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3008, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_300C, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 1, 32'h3100,     1, 0, 32'h0,        32'h0000_3010, 0, 1, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3100, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 1, 32'h3020,     0, 0, 32'h0,        32'h0000_3104, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3020, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3020, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_4180, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 1, 32'h3200,     1, 1, 32'h3044,     32'h0000_4184, 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3044, 0, 0, 0, 1));
      tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 1, 32'h3060,     32'h0000_3048, 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 1, 32'h3060,     32'h0000_3048, 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 1, 32'h3060,     32'h0000_3048, 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3060, 0, 0, 0, 1));
      tbl.push_back(v(0, 0, 1, 1, 32'h3002,     0, 0, 32'h0,        32'h0000_3064, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3002, 1, 0, 4, 0));
      tbl.push_back(v(0, 0, 1, 1, 32'h7000,     1, 0, 32'h0,        32'h0000_3006, 1, 1, 4, 0));
      tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_7000, 1, 0, 4, 0));
      tbl.push_back(v(0, 0, 1, 1, 32'h2FFC,     0, 0, 32'h0,        32'h0000_7004, 1, 0, 4, 0));
      tbl.push_back(v(0, 0, 1, 1, 32'h6FFC,     0, 0, 32'h0,        32'h0000_2FFC, 1, 0, 4, 0));
      tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_6FFC, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 1, 1, 32'h3300,     0, 1, 32'h3500,     32'h0000_7000, 1, 0, 4, 0));
      tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_4180, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 1, 32'h3400,     0, 0, 32'h0,        32'h0000_4184, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 1, 32'h3400,     0, 0, 32'h0,        32'h0000_4184, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 1, 32'h3400,     0, 0, 32'h0,        32'h0000_4184, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,       32'h0000_3400, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        32'hFFFF_FFFC, 1, 0, 4, 0));
      tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_0000, 1, 0, 4, 0));
      tbl.push_back(v(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_0004, 1, 0, 4, 0));
      tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_4180, 0, 0, 0, 0));
      reset = 1'b1; bus.Req = 1'b0; bus.WE = 1'b1; bus.D_redirect = 1'b0; bus.D_target = '0;
      bus.D_is_cti = 1'b0; bus.D_eret = 1'b0; bus.EPC = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("row%0d", i));
      // reset beats a simultaneous Req and branch
      step(v(1, 1, 1, 1, 32'h3100, 0, 0, 32'h0,    32'h0000_4184, 0, 0, 0, 0), "rst_mid0");
      step(v(0, 0, 1, 0, 32'h0,    0, 0, 32'h0,    32'h0000_3000, 0, 0, 0, 0), "rst_mid1");
      step(v(0, 0, 1, 0, 32'h0,    0, 1, 32'h3050, 32'h0000_3004, 1, 0, 0, 0), "esq0");
      step(v(0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    32'h0000_3050, 0, 0, 0, 1), "esq1");
      step(v(0, 1, 0, 0, 32'h0,    0, 0, 32'h0,    32'h0000_3050, 0, 0, 0, 1), "esq2");
      step(v(0, 0, 1, 0, 32'h0,    0, 0, 32'h0,    32'h0000_4180, 0, 0, 0, 0), "esq3");
      step(v(0, 0, 1, 0, 32'h0,    0, 1, 32'h3070, 32'h0000_4184, 1, 0, 0, 0), "esq4");
      step(v(1, 0, 1, 0, 32'h0,    0, 0, 32'h0,    32'h0000_3070, 0, 0, 0, 1), "esq5");
      step(v(0, 0, 1, 0, 32'h0,    0, 0, 32'h0,    32'h0000_3000, 0, 0, 0, 0), "esq6");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
